// File: rtl/seq_addsub_pkg.sv
// seq_addsub_pkg: shared FSM state type and counter-width helper for seq_addsub
package seq_addsub_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_addsub_if.sv
// seq_addsub_if: start/busy/done operand and result bundle for seq_addsub
interface seq_addsub_if #(parameter int WIDTH = 16);
  logic             start, cin, sub, cout, ovf, busy, done;
  logic [WIDTH-1:0] a, b, s;
  modport master (output start, a, b, cin, sub, input s, cout, ovf, busy, done);
  modport slave  (input start, a, b, cin, sub, output s, cout, ovf, busy, done);
endinterface

// File: rtl/seq_addsub_fa_chunk.sv
// fa_chunk: combinational W-bit ripple adder built from a per-bit full adder
module fa_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);
  function automatic logic [1:0] fa(input logic p, input logic q, input logic c);
    return {(p & q) | (c & (p ^ q)), p ^ q ^ c};
  endfunction
  logic [W:0] c;
  always_comb begin
    c[0] = ci;
    for (int i = 0; i < W; i++) {c[i+1], sum[i]} = fa(x[i], y[i], c[i]);
  end
  assign co = c[W];
endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle add/subtract, CHUNK bits per cycle through one shared chunk adder
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_addsub_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = clog2_min1(NCHUNK);
  if (WIDTH < 1 || CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("seq_addsub: CHUNK must be >= 1 and divide WIDTH exactly");
  end
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q, cout_q, ovf_q, busy_q, done_q;
  logic [CHUNK-1:0] xa, yb, sum;
  logic             co, last;
  assign xa   = a_q[int'(cnt_q) * CHUNK +: CHUNK];
  assign yb   = b_q[int'(cnt_q) * CHUNK +: CHUNK];
  assign last = cnt_q == CW'(NCHUNK - 1);
  fa_chunk #(.W(CHUNK)) u_fa (.x(xa), .y(yb), .ci(carry_q), .sum(sum), .co(co));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CALC: begin
          s_q[int'(cnt_q) * CHUNK +: CHUNK] <= sum;
          carry_q <= co;
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= co;
            ovf_q   <= (xa[CHUNK-1] == yb[CHUNK-1]) && (sum[CHUNK-1] != xa[CHUNK-1]);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          // subtract is a + ~b + ~borrow_in, so only the operand capture differs
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ^ bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: vector table, corner sequences and random sweep for 16/4 and 8/8 configurations
module tb_seq_addsub;
  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n16 = 0;
  int   n8 = 0;
  exp_t q16[$];
  exp_t q8[$];
  exp_t e16, e8;

  seq_addsub_if #(.WIDTH(16)) i16 ();
  seq_addsub_if #(.WIDTH(8))  i8 ();
  seq_addsub #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst(rst), .bus(i16.slave));
  seq_addsub #(.WIDTH(8),  .CHUNK(8)) u8  (.clk(clk), .rst(rst), .bus(i8.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", n, act, want);
    end
  endtask

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    logic [31:0] m, aa, bb, t;
    exp_t e;
    m  = (32'd1 << w) - 32'd1;
    aa = {16'd0, a} & m;
    bb = (sub ? ~{16'd0, b} : {16'd0, b}) & m;
    t  = aa + bb + {31'd0, sub ^ cin};
    e.s    = t[15:0] & m[15:0];
    e.cout = t[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (t[w-1] != aa[w-1]);
    return e;
  endfunction

  // scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (i16.done) begin
      n16++;
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done16: unexpected done pulse, s=0x%0h", i16.s);
      end else begin
        e16 = q16.pop_front();
        chk("s16", {16'd0, i16.s}, {16'd0, e16.s});
        chk("cout16", {31'd0, i16.cout}, {31'd0, e16.cout});
        chk("ovf16", {31'd0, i16.ovf}, {31'd0, e16.ovf});
      end
    end
    if (i8.done) begin
      n8++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8: unexpected done pulse, s=0x%0h", i8.s);
      end else begin
        e8 = q8.pop_front();
        chk("s8", {24'd0, i8.s}, {24'd0, e8.s[7:0]});
        chk("cout8", {31'd0, i8.cout}, {31'd0, e8.cout});
        chk("ovf8", {31'd0, i8.ovf}, {31'd0, e8.ovf});
      end
    end
  end

  task automatic op(input bit w8, input logic [15:0] a, input logic [15:0] b,
                    input logic cin, input logic sub, input exp_t e);
    int lat = 0;
    int bsy = 0;
    if (w8) begin
      i8.a = a[7:0]; i8.b = b[7:0]; i8.cin = cin; i8.sub = sub; i8.start = 1'b1;
      q8.push_back(e);
    end else begin
      i16.a = a; i16.b = b; i16.cin = cin; i16.sub = sub; i16.start = 1'b1;
      q16.push_back(e);
    end
    tick();
    i8.start = 1'b0;
    i16.start = 1'b0;
    while (!(w8 ? i8.done : i16.done) && lat < 20) begin
      bsy += int'(w8 ? i8.busy : i16.busy);
      tick();
      lat++;
    end
    chk(w8 ? "latency8" : "latency16", lat, w8 ? 1 : 4);
    chk(w8 ? "busy_cycles8" : "busy_cycles16", bsy, w8 ? 1 : 4);
  endtask

  initial begin
    vec_t tbl[7];
    int   d, snap;
    logic [15:0] ra, rb;
    logic rc, rs;
    tbl[0] = {16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = {16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = {16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = {16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = {16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = {16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[6] = {16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
    rst = 1'b1;
    {i16.start, i16.a, i16.b, i16.cin, i16.sub} = '0;
    {i8.start, i8.a, i8.b, i8.cin, i8.sub} = '0;
    tick();
    tick();
    chk("rst_s16", {16'd0, i16.s}, 32'd0);
    chk("rst_cout16", {31'd0, i16.cout}, 32'd0);
    chk("rst_ovf16", {31'd0, i16.ovf}, 32'd0);
    chk("rst_busy16", {31'd0, i16.busy}, 32'd0);
    chk("rst_done16", {31'd0, i16.done}, 32'd0);
    chk("rst_s8", {24'd0, i8.s}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      op(1'b0, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].e);
      tick();
      tick();
      tick();
      chk("hold_s16", {16'd0, i16.s}, {16'd0, tbl[i].e.s});
      chk("hold_cout16", {31'd0, i16.cout}, {31'd0, tbl[i].e.cout});
    end

    // start during busy is ignored; start held in the DONE cycle chains a second op
    i16.a = 16'h1111; i16.b = 16'h2222; i16.cin = 1'b0; i16.sub = 1'b0; i16.start = 1'b1;
    q16.push_back({16'h3333, 1'b0, 1'b0});
    tick();
    i16.start = 1'b0;
    tick();
    i16.a = 16'hFFFF; i16.b = 16'hFFFF; i16.sub = 1'b1; i16.start = 1'b1;
    tick();
    i16.start = 1'b0;
    d = 0;
    while (!i16.done && d < 20) begin
      tick();
      d++;
    end
    chk("first_done_seen", {31'd0, i16.done}, 32'd1);
    i16.a = 16'h0001; i16.b = 16'h0002; i16.cin = 1'b0; i16.sub = 1'b0; i16.start = 1'b1;
    q16.push_back({16'h0003, 1'b0, 1'b0});
    tick();
    i16.start = 1'b0;
    d = 1;
    while (!i16.done && d < 20) begin
      tick();
      d++;
    end
    chk("b2b_gap", d, 5);
    tick();
    tick();

    // reset at cnt=2 aborts without a done pulse
    i16.a = 16'h1234; i16.b = 16'h4321; i16.start = 1'b1;
    tick();
    i16.start = 1'b0;
    tick();
    tick();
    snap = n16;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'd0, i16.busy}, 32'd0);
    chk("abort_done", {31'd0, i16.done}, 32'd0);
    chk("abort_s", {16'd0, i16.s}, 32'd0);
    chk("abort_cout", {31'd0, i16.cout}, 32'd0);
    repeat (8) tick();
    chk("abort_no_done", n16, snap);

    op(1'b1, 16'h00C8, 16'h0064, 1'b1, 1'b0, {16'h002D, 1'b1, 1'b0});
    tick();

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      op(1'b0, ra, rb, rc, rs, model(16, ra, rb, rc, rs));
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      op(1'b1, ra, rb, rc, rs, model(8, ra, rb, rc, rs));
    end
    tick();
    tick();
    chk("q16_drained", q16.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor. It is the successor to the fixed-width combinational full adder.
- Adds or subtracts two WIDTH-bit operands, processing CHUNK bits per clock. Carry ripples between chunks through a carry register.
- Uses a start/busy/done handshake. It serves as the shared arithmetic block for the team's area-constrained datapaths, trading latency for small adder area.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 1.
- CHUNK, 4, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).
- NCHUNK (localparam), WIDTH/CHUNK, number of compute cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in (borrow-in when sub=1); captured when start is accepted.
- sub  input  1  0 = add, 1 = subtract; captured when start is accepted.
- s  output  WIDTH  result register.
- cout  output  1  final carry out (sub: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; result valid.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; s=0, cout=0, ovf=0, busy=0, done=0; chunk counter=0; carry register=0. Reset mid-CALC aborts the operation with no done pulse.
- FSM states: IDLE, CALC, DONE.
  - IDLE, start=1: latch operands; go to CALC with cnt=0.
  - CALC, cnt<NCHUNK-1: cnt++.
  - CALC, cnt=NCHUNK-1: go to DONE.
  - DONE, start=1: latch new operands; go to CALC (back-to-back operation).
  - DONE, start=0: go to IDLE.
- Operand capture at accept:
  - a_r = a.
  - b_r = sub ? ~b : b.
  - carry register = sub ? ~cin : cin.
  - Subtract therefore computes a - b - cin.
- CALC step at each edge: chunk k=cnt adds a_r[k*CHUNK +: CHUNK] + b_r[same] + carry. Sum is written to s[same slice]; chunk carry-out goes to the carry register. Untouched slices of s keep their previous values; s is undefined-in-use (not checked) until done.
- Last chunk edge:
  - cout = carry out of the MSB chunk.
  - ovf = (a_r[MSB] == b_r[MSB]) && (sum[MSB] != a_r[MSB]).
- Latency: start accepted at edge E0. done=1 during the cycle after edge E_NCHUNK, i.e. NCHUNK+1 rising edges after start is first seen high. busy=1 exactly NCHUNK cycles.
- Output hold: s, cout and ovf hold their value after done until the next accepted start. The next accepted start does not clear them; they are overwritten chunk by chunk.
- start while busy: ignored, no queuing. Operands on a/b/cin/sub are don't-care except at accept.
- NCHUNK=1 (CHUNK=WIDTH): a single CALC cycle, behaving as a registered adder; done at E0+2.
- cnt width = max(1, $clog2(NCHUNK)). No wrap beyond NCHUNK-1.

Decomposition:
- Package seq_addsub_pkg holds:
  - state enum (IDLE, CALC, DONE), 2-bit encoded;
  - function clog2_min1 for counter width.
- One sub-module, fa_chunk: purely combinational CHUNK-bit ripple full adder built from a per-bit full-adder function. Inputs x, y, ci; outputs sum, co. Instantiated once and shared across chunks via slice muxing.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- a=0x1234, b=0x4321, cin=0, sub=0, start pulse -> busy high 4 cycles; done at E0+5; s=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> s=0x0000, cout=1, ovf=0 (carry ripples through all chunks). Also a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1.
- a=0x0005, b=0x0007, cin=0, sub=1 -> s=0xFFFE, cout=0 (borrow), ovf=0. Also a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1.
- start re-asserted with different operands during busy -> ignored; first result unchanged. start held high in the DONE cycle with a=0x0001, b=0x0002 -> second done exactly 5 cycles after the first, s=0x0003.
- rst asserted at cnt=2 mid-CALC -> next cycle: IDLE, busy=0, done never pulses, s=0, cout=0.
- Re-elaborate with WIDTH=8, CHUNK=8: a=0xC8, b=0x64, cin=1 -> s=0x2D, cout=1; done at E0+2. Sweep 1000 random vectors against a reference model for both configurations.
